// File: rtl/subsurf_pkg.sv
// Shared types and constants for the mesh loader: FSM states, default sizes
// and the header field layout of the upstream object stream.
package subsurf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    KICK,
    WAIT_BUSY,
    WAIT_DONE
  } state_e;

  localparam int DEPTH_DEF        = 512;
  localparam int KICK_TIMEOUT_DEF = 16;

  localparam int ADDR_W = 9;
  localparam int CNT_W  = 10;
  localparam int TMO_W  = 5;

  localparam int HDR_N_LSB = 0;
  localparam int HDR_N_W   = 10;

  function automatic logic hdr_len_ok(input logic [HDR_N_W-1:0] n, input int depth);
    return (n != '0) && (int'(n) <= depth);
  endfunction

endpackage

// File: rtl/mesh_loader.sv
// Streams a header plus N payload words into the object RAM (one registered write per beat),
// then kicks the subdivision top and waits for it; s_ready is low from the final write onward.
module mesh_loader
  import subsurf_pkg::*;
#(
  parameter int DEPTH        = DEPTH_DEF,
  parameter int KICK_TIMEOUT = KICK_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_valid,
  input  logic [31:0]       s_data,
  output logic              s_ready,
  output logic              ram_en,
  output logic [ADDR_W-1:0] ram_a,
  output logic [3:0]        ram_we,
  output logic [31:0]       ram_di,
  output logic              ss_start,
  input  logic              ss_busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  loaded
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   loaded_q, loaded_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               alive_q;
  logic               ram_en_q, ram_en_d;
  logic [3:0]         ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]  ram_a_q, ram_a_d;
  logic [31:0]        ram_di_q, ram_di_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               beat;
  logic [HDR_N_W-1:0] hdr_n;

  // alive_q holds s_ready low through reset and for the cycle it is released
  assign s_ready  = alive_q && (state_q == IDLE || state_q == LOAD);
  assign ss_start = (state_q == KICK);
  assign beat     = s_valid && s_ready;
  assign hdr_n    = s_data[HDR_N_LSB +: HDR_N_W];

  assign ram_en = ram_en_q;
  assign ram_we = ram_we_q;
  assign ram_a  = ram_a_q;
  assign ram_di = ram_di_q;
  assign done   = done_q;
  assign err    = err_q;
  assign loaded = loaded_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      cnt_q    <= '0;
      loaded_q <= '0;
      tmo_q    <= '0;
      alive_q  <= 1'b0;
      ram_en_q <= 1'b0;
      ram_we_q <= 4'h0;
      ram_a_q  <= '0;
      ram_di_q <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      cnt_q    <= cnt_d;
      loaded_q <= loaded_d;
      tmo_q    <= tmo_d;
      alive_q  <= 1'b1;
      ram_en_q <= ram_en_d;
      ram_we_q <= ram_we_d;
      ram_a_q  <= ram_a_d;
      ram_di_q <= ram_di_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    cnt_d    = cnt_q;
    loaded_d = loaded_q;
    tmo_d    = tmo_q;
    ram_en_d = 1'b0;
    ram_we_d = 4'h0;
    ram_a_d  = ram_a_q;
    ram_di_d = ram_di_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (beat) begin
          if (hdr_len_ok(hdr_n, DEPTH)) begin
            n_d      = hdr_n;
            cnt_d    = '0;
            loaded_d = '0;
            state_d  = LOAD;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          ram_en_d = 1'b1;
          ram_we_d = 4'hF;
          ram_a_d  = cnt_q[ADDR_W-1:0];
          ram_di_d = s_data;
          loaded_d = loaded_q + 1'b1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == n_q - 1'b1) state_d = KICK;
        end
      end
      KICK: begin
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (ss_busy) begin
          state_d = WAIT_DONE;
        end else begin
          if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
          // tmo_q counts from the first WAIT_BUSY cycle; err lands KICK_TIMEOUT cycles after ss_start
          if (int'(tmo_q) + 2 >= KICK_TIMEOUT) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!ss_busy) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mesh_loader.sv
// Randomized bench for mesh_loader with a transaction-level reference model.
module tb_mesh_loader;

  localparam int TMO = 16;

  logic        clk;
  logic        rst_n;
  logic        s_valid;
  logic [31:0] s_data;
  logic        s_ready;
  logic        ram_en;
  logic [8:0]  ram_a;
  logic [3:0]  ram_we;
  logic [31:0] ram_di;
  logic        ss_start;
  logic        ss_busy;
  logic        done;
  logic        err;
  logic [9:0]  loaded;

  mesh_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_data   (s_data),
    .s_ready  (s_ready),
    .ram_en   (ram_en),
    .ram_a    (ram_a),
    .ram_we   (ram_we),
    .ram_di   (ram_di),
    .ss_start (ss_start),
    .ss_busy  (ss_busy),
    .done     (done),
    .err      (err),
    .loaded   (loaded)
  );

  typedef struct {
    int          c;
    logic [8:0]  a;
    logic [31:0] d;
    logic [3:0]  we;
    logic [9:0]  ld;
  } wr_t;

  wr_t wr_q[$];
  int  err_q[$];
  int  done_q[$];
  int  start_q[$];
  int  cyc;
  int  ovl;
  int  n_cmp;
  int  n_bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial ovl = 0;
  always @(posedge clk) begin
    #1;
    if (ram_en) wr_q.push_back('{cyc, ram_a, ram_di, ram_we, loaded});
    if (err) err_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
    if (ss_start) start_q.push_back(cyc);
    if (done && err) ovl++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_logs();
    wr_q.delete();
    err_q.delete();
    done_q.delete();
    start_q.delete();
  endtask

  // Called at a negedge; returns the cycle in which the beat was accepted.
  task automatic send_beat(input logic [31:0] d, output int acc);
    s_valid = 1'b1;
    s_data  = d;
    acc     = -1;
    for (int w = 0; w < 100 && !s_ready; w++) @(negedge clk);
    if (!s_ready) chk("rdy_wait", s_ready, 1);
    else acc = cyc;
    @(negedge clk);
  endtask

  function automatic logic [31:0] mk_hdr(input int n);
    logic [31:0] w;
    w = $urandom();
    return (w & 32'hFFFF_FC00) | 32'(n);
  endfunction

  // gap >= 0: fixed idle cycles between beats; gap < 0: random 0..3 before each beat.
  // bdly >= TMO: ss_busy never rises, so a timeout is expected.
  task automatic run_xfer(input int n, input int gap, input int bdly, input int blen);
    logic [31:0] w;
    int a, s, expd, g;
    int acc[$];
    logic [31:0] dat[$];
    clear_logs();
    send_beat(mk_hdr(n), a);
    for (int k = 0; k < n; k++) begin
      g = (gap >= 0) ? ((k > 0) ? gap : 0) : int'($urandom_range(3, 0));
      s_valid = 1'b0;
      repeat (g) begin
        chk("gap_rdy", s_ready, 1);
        @(negedge clk);
      end
      w = $urandom();
      dat.push_back(w);
      send_beat(w, a);
      acc.push_back(a);
    end
    s_valid = 1'b0;
    s = cyc;
    chk("rdy_drop", s_ready, 0);
    chk("kick", ss_start, 1);
    if (bdly < TMO) begin
      repeat (bdly) @(negedge clk);
      ss_busy = 1'b1;
      repeat (blen) @(negedge clk);
      ss_busy = 1'b0;
      expd = cyc + 1;
      repeat (2) @(negedge clk);
      chk("done_cnt", done_q.size(), 1);
      if (done_q.size() > 0) chk("done_cyc", done_q[0], expd);
      chk("ok_err_cnt", err_q.size(), 0);
    end else begin
      repeat (TMO) @(negedge clk);
      chk("to_rdy", s_ready, 1);
      @(negedge clk);
      chk("to_err_cnt", err_q.size(), 1);
      if (err_q.size() > 0) chk("to_err_cyc", err_q[0], s + TMO);
      chk("to_done_cnt", done_q.size(), 0);
    end
    chk("start_cnt", start_q.size(), 1);
    if (start_q.size() > 0) chk("start_cyc", start_q[0], s);
    chk("wr_cnt", wr_q.size(), n);
    for (int i = 0; i < n && i < wr_q.size(); i++) begin
      chk("wr_a", wr_q[i].a, i);
      chk("wr_d", wr_q[i].d, dat[i]);
      chk("wr_we", wr_q[i].we, 4'hF);
      chk("wr_loaded", wr_q[i].ld, i + 1);
      chk("wr_cyc", wr_q[i].c, acc[i] + 1);
    end
  endtask

  task automatic bad_hdr(input int n);
    int a;
    clear_logs();
    send_beat(mk_hdr(n), a);
    s_valid = 1'b0;
    chk("bad_rdy", s_ready, 1);
    @(negedge clk);
    chk("bad_err_cnt", err_q.size(), 1);
    if (err_q.size() > 0) chk("bad_err_cyc", err_q[0], a + 1);
    chk("bad_wr_cnt", wr_q.size(), 0);
    chk("bad_start_cnt", start_q.size(), 0);
  endtask

  initial begin
    int a, n, bdly;
    n_cmp   = 0;
    n_bad   = 0;
    rst_n   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    ss_busy = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", {s_ready, ram_en, ram_a, ram_we, ram_di, ss_start, done, err, loaded}, 0);
    rst_n = 1'b1;
    #1 chk("rst_rdy_low", s_ready, 0);
    @(negedge clk);
    chk("rst_rdy_rise", s_ready, 1);

    run_xfer(3, 0, 2, 3);
    run_xfer(2, 4, 3, 2);
    bad_hdr(0);
    bad_hdr(600);
    bad_hdr(513);
    run_xfer(1, 0, TMO, 0);
    run_xfer(1, 0, TMO - 1, 1);

    // reset in the middle of a 10-word load
    clear_logs();
    send_beat(mk_hdr(10), a);
    for (int k = 0; k < 5; k++) send_beat($urandom(), a);
    s_valid = 1'b0;
    rst_n   = 1'b0;
    #1 chk("mid_rst_outs", {s_ready, ram_en, ram_a, ram_we, ram_di, ss_start, done, err, loaded}, 0);
    chk("mid_rst_wr_cnt", wr_q.size(), 5);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("mid_rst_rdy_low", s_ready, 0);
    @(negedge clk);
    chk("mid_rst_rdy_rise", s_ready, 1);
    chk("mid_rst_no_wr", wr_q.size(), 5);
    run_xfer(4, 0, 4, 2);

    run_xfer(512, 0, 5, 4);

    for (int t = 0; t < 14; t++) begin
      n    = $urandom_range(24, 1);
      bdly = ($urandom_range(5, 0) == 0) ? TMO : int'($urandom_range(15, 1));
      run_xfer(n, -1, bdly, $urandom_range(8, 1));
      if ($urandom_range(3, 0) == 0) bad_hdr($urandom_range(1023, 513));
    end

    chk("done_err_overlap", ovl, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
